// File: rtl/period_capture_pkg.sv
// Shared definitions for the period capture block: FSM state encodings.
package period_capture_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous input and flags its rising edges for one cycle.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   delay;

    // The delay flop holds the previous synchronised level for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= '0;
            delay <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], d_async};
            delay <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~delay;

endmodule

// File: rtl/period_capture.sv
// Measures clk cycles between rising edges of an asynchronous pulse input.
module period_capture
    import period_capture_pkg::*;
#(
    parameter int NBITS       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [NBITS-1:0] period,
    output logic             valid,
    output logic             overflow
);

    localparam logic [NBITS-1:0] CNT_MAX = '1;

    state_t           state;
    logic [NBITS-1:0] counter;
    logic             rise;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk    (clk),
        .rst    (rst),
        .d_async(pulse_in),
        .rise   (rise)
    );

    // Disable outranks everything; in MEAS a rise outranks the overflow at max count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            counter  <= '0;
            period   <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!enable) begin
                state   <= ST_IDLE;
                counter <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        counter <= '0;
                        state   <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (rise) begin
                            counter <= '0;
                            state   <= ST_MEAS;
                        end
                    end
                    ST_MEAS: begin
                        if (rise) begin
                            period   <= counter;
                            valid    <= 1'b1;
                            overflow <= 1'b0;
                            counter  <= '0;
                        end else if (counter == CNT_MAX) begin
                            overflow <= 1'b1;
                            counter  <= '0;
                            state    <= ST_ARM;
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                    default: begin
                        counter <= '0;
                        state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
